// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the oversampled UART receiver slice.
//   state_t           receiver FSM state encoding
//   DEF_CLKS_PER_BIT  default clk cycles per serial bit
//   DEF_DATA_BITS     default data bits per frame
//   LINE_IDLE         level of an idle serial line
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int   DEF_CLKS_PER_BIT = 10;
    localparam int   DEF_DATA_BITS    = 8;
    localparam logic LINE_IDLE        = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        LOAD
    } state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_if
// Byte-side handshake between the receiver and the byte consumer.
//   data_read      consumer -> receiver, one-cycle acknowledge of rx_data
//   rx_data        last good frame payload
//   data_ready     rx_data holds an unread frame
//   overrun_error  a frame was loaded while the previous one was unread
//   framing_error  last frame had stop bit = 0
//   parity_error   parity mismatch on the last loaded frame
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_ctrl_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) ();

    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 overrun_error;
    logic                 framing_error;
    logic                 parity_error;

    modport master (
        input  data_read,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error,
        output parity_error
    );

    modport slave (
        output data_read,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error,
        input  parity_error
    );

endinterface : uart_rx_ctrl_if

// File: rtl/uart_rx_sr.sv
// -----------------------------------------------------------------------------
// uart_rx_sr
// Right-shifting deserialiser. Each enabled cycle the new bit enters the MSB,
// so a frame arriving LSB-first ends up LSB-aligned after WIDTH shifts.
//   clk           system clock
//   n_rst         asynchronous active-low reset (register -> all ones)
//   shift_enable  shift in serial_bit this cycle
//   serial_bit    sampled line value
//   parallel_out  current register contents
// -----------------------------------------------------------------------------
module uart_rx_sr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             shift_enable,
    input  logic             serial_bit,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] r_shift;

    // NOTE: the shift register is reset to all ones (an idle line's worth of
    // bits); it is small flop storage, not a RAM, so a reset costs nothing.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift <= '1;
        end else if (shift_enable) begin
            // NOTE: non-blocking assignment keeps every flop updating from
            // pre-edge values, independent of statement order.
            r_shift <= {serial_bit, r_shift[WIDTH-1:1]};
        end
    end

    assign parallel_out = r_shift;

endmodule : uart_rx_sr

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Oversampled asynchronous serial receiver: 2-flop synchroniser, falling-edge
// start detection with mid-bit qualification, mid-bit data sampling,
// LSB-first deserialisation, stop-bit check and a single-entry output buffer
// acknowledged through data_read.
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   serial_in  raw asynchronous line, idle high
//   rx_if      uart_rx_ctrl_if.master: data_read in; rx_data, data_ready,
//              overrun_error, framing_error, parity_error out
// Optional feature: define UART_RX_PARITY_EN to receive one even-parity bit
// between the data bits and the stop bit; otherwise parity_error is tied 0.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           serial_in,
    uart_rx_ctrl_if.master rx_if
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);

    // The timer starts at 0 on the first cycle of a period, so the sample
    // lands on the cycle where it holds target-1.
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    // Synchroniser and edge detect
    logic r_sync1;
    logic r_sync2;
    logic r_line_prev;
    logic w_line;
    logic w_fall;

    // FSM
    state_t r_state;
    state_t w_state_next;

    // Bit-period timer
    logic [TW-1:0] r_timer;
    logic          w_timer_clr;
    logic          w_tick;

    // Bit-index counter
    logic [BW-1:0] r_bit_cnt;
    logic          w_bit_cnt_clr;
    logic          w_bit_cnt_en;
    logic          w_bit_last;

    // Datapath strobes
    logic                 w_shift_en;
    logic [DATA_BITS-1:0] w_shift_data;
    logic                 w_start_ok;
    logic                 w_stop_sample;
    logic                 w_load;
    logic                 r_stop_bit;

`ifdef UART_RX_PARITY_EN
    logic w_par_sample;
    logic r_par_bit;
    logic w_par_mismatch;
`endif

    // Output buffer
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_overrun_error;
    logic                 r_framing_error;
    logic                 r_parity_error;

    // -------------------------------------------------------------------------
    // Synchroniser: the line resets to idle so reset never looks like an edge
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1     <= LINE_IDLE;
            r_sync2     <= LINE_IDLE;
            r_line_prev <= LINE_IDLE;
        end else begin
            r_sync1     <= serial_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = (w_line != LINE_IDLE) && (r_line_prev == LINE_IDLE);

    // -------------------------------------------------------------------------
    // Bit-period timer: restarts on every state change and after each sample
    // -------------------------------------------------------------------------
    assign w_tick      = (r_state == START) ? (r_timer == HALF_LAST)
                                            : (r_timer == FULL_LAST);
    assign w_timer_clr = (w_state_next != r_state);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_timer <= '0;
        end else if (w_timer_clr || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Bit-index counter: held clear outside DATA, counts data samples
    // -------------------------------------------------------------------------
    assign w_bit_cnt_clr = (r_state != DATA);
    assign w_bit_cnt_en  = w_shift_en;
    assign w_bit_last    = (r_bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_cnt <= '0;
        end else if (w_bit_cnt_clr) begin
            r_bit_cnt <= '0;
        end else if (w_bit_cnt_en) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        w_state_next  = r_state;
        w_start_ok    = 1'b0;
        w_shift_en    = 1'b0;
        w_stop_sample = 1'b0;
        w_load        = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    // A line back high at mid start bit is a glitch
                    if (w_line == LINE_IDLE) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_start_ok   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (w_bit_last) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_tick) begin
                    w_par_sample = 1'b1;
                    w_state_next = STOP;
                end
`else
                w_state_next = IDLE;
`endif
            end
            STOP: begin
                if (w_tick) begin
                    w_stop_sample = 1'b1;
                    w_state_next  = LOAD;
                end
            end
            LOAD: begin
                w_load       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Deserialiser
    // -------------------------------------------------------------------------
    uart_rx_sr #(
        .WIDTH (DATA_BITS)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (w_shift_en),
        .serial_bit   (w_line),
        .parallel_out (w_shift_data)
    );

    // Stop (and parity) bits are captured so LOAD can act on them a cycle later
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stop_bit <= LINE_IDLE;
        end else if (w_stop_sample) begin
            r_stop_bit <= w_line;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_par_bit <= 1'b0;
        end else if (w_par_sample) begin
            r_par_bit <= w_line;
        end
    end

    // Even parity: data plus parity bit must hold an even number of ones
    assign w_par_mismatch = ^{w_shift_data, r_par_bit};
`endif

    // -------------------------------------------------------------------------
    // Output buffer. A good LOAD takes priority over a coincident data_read:
    // the new frame is unread, so data_ready stays set and no overrun is
    // flagged. Overrun and parity flags only exist while data_ready is set,
    // so a read with nothing buffered changes nothing.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data       <= '1;
            r_data_ready    <= 1'b0;
            r_overrun_error <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_framing_error <= 1'b0;
            end

            if (w_load && r_stop_bit) begin
                r_rx_data    <= w_shift_data;
                r_data_ready <= 1'b1;
                if (r_data_ready && !rx_if.data_read) begin
                    r_overrun_error <= 1'b1;
                end else if (rx_if.data_read) begin
                    r_overrun_error <= 1'b0;
                end
`ifdef UART_RX_PARITY_EN
                r_parity_error <= w_par_mismatch;
`endif
            end else begin
                if (w_load) begin
                    r_framing_error <= 1'b1;
                end
                if (rx_if.data_read && r_data_ready) begin
                    r_data_ready    <= 1'b0;
                    r_overrun_error <= 1'b0;
                    r_parity_error  <= 1'b0;
                end
            end
        end
    end

    assign rx_if.rx_data       = r_rx_data;
    assign rx_if.data_ready    = r_data_ready;
    assign rx_if.overrun_error = r_overrun_error;
    assign rx_if.framing_error = r_framing_error;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_error  = r_parity_error;
`else
    assign rx_if.parity_error  = 1'b0;
`endif

endmodule : uart_rx_ctrl
